// File: rtl/trig_pkg.sv
// Shared definitions for the trigger conditioner: debounce FSM encoding and
// the default duration loaded at reset.
package trig_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } deb_state_e;

  localparam logic [7:0] DUR_RESET_DEF = 8'd2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; both stages clear to 0
// on reset so the synchronised output starts low.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/trigger_conditioner.sv
// Front end for one_shot: synchronises and debounces raw_in, emits a one-cycle
// trig on qualified rising edges, owns the duration register and counts drops.
module trigger_conditioner
  import trig_pkg::*;
#(
  parameter int                 DEB_CYCLES = 4,
  parameter int                 DUR_W      = 8,
  parameter logic [DUR_W-1:0]   DUR_RESET  = DUR_W'(DUR_RESET_DEF),
  parameter int                 CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_in,
  input  logic             busy,
  input  logic             cfg_valid,
  input  logic [DUR_W-1:0] cfg_dur,
  output logic             cfg_ready,
  output logic             trig,
  output logic [DUR_W-1:0] dur,
  output logic             load,
  output logic             deb_level,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

  logic             s_in;
  logic [1:0]       vld_q;
  logic             armed_q, armed_d;
  deb_state_e       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             deb_q, deb_d;
  logic             deb_prev_q;
  logic             trig_q, trig_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             load_q, load_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic             deb_rise;
  logic             cfg_accept;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (raw_in),
    .q_o   (s_in)
  );

  // s_in only reflects raw_in once both sync stages have refilled after reset;
  // a genuine low must be seen before any rise is accepted.
  assign armed_d = armed_q | (vld_q[1] & ~s_in);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    unique case (state_q)
      LOW: begin
        deb_d = 1'b0;
        if (s_in && armed_q) begin
          if (DEB_CYCLES == 1) begin
            state_d = HIGH;
            deb_d   = 1'b1;
          end else begin
            state_d = RISE_CHK;
            cnt_d   = 8'd1;
          end
        end
      end
      RISE_CHK: begin
        if (!s_in) begin
          state_d = LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          deb_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HIGH: begin
        deb_d = 1'b1;
        if (!s_in) begin
          if (DEB_CYCLES == 1) begin
            state_d = LOW;
            deb_d   = 1'b0;
          end else begin
            state_d = FALL_CHK;
            cnt_d   = 8'd1;
          end
        end
      end
      FALL_CHK: begin
        if (s_in) begin
          state_d = HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW;
          deb_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = LOW;
    endcase
  end

  assign deb_rise   = deb_q & ~deb_prev_q;
  assign cfg_ready  = ~busy;
  assign cfg_accept = cfg_valid & ~busy;

  always_comb begin
    trig_d = deb_rise & ~busy & load_q;
    dur_d  = cfg_accept ? cfg_dur : dur_q;
    load_d = load_q | cfg_accept;
    miss_d = miss_q;
    if (deb_rise && (busy || !load_q) && (miss_q != {CNT_W{1'b1}})) begin
      miss_d = miss_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q      <= 2'b00;
      armed_q    <= 1'b0;
      state_q    <= LOW;
      cnt_q      <= 8'd0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      trig_q     <= 1'b0;
      dur_q      <= DUR_RESET;
      load_q     <= 1'b0;
      miss_q     <= '0;
    end else begin
      vld_q      <= {vld_q[0], 1'b1};
      armed_q    <= armed_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      trig_q     <= trig_d;
      dur_q      <= dur_d;
      load_q     <= load_d;
      miss_q     <= miss_d;
    end
  end

  assign trig      = trig_q;
  assign dur       = dur_q;
  assign load      = load_q;
  assign deb_level = deb_q;
  assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_trigger_conditioner.sv
// Directed bench for trigger_conditioner with a scoreboard of expected trig
// pulses (cycle and duration) checked as the DUT produces them.
module tb_trigger_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic       raw_in;
  logic       busy;
  logic       cfg_valid;
  logic [7:0] cfg_dur;
  logic       cfg_ready;
  logic       trig;
  logic [7:0] dur;
  logic       load;
  logic       deb_level;
  logic [7:0] miss_cnt;

  typedef struct {
    int         cyc;
    logic [7:0] dur;
  } trig_exp_t;

  trig_exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_exp    = 0;

  always #10 clk = ~clk;

  trigger_conditioner #(
    .DEB_CYCLES (4),
    .DUR_W      (8),
    .DUR_RESET  (8'd2),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .busy      (busy),
    .cfg_valid (cfg_valid),
    .cfg_dur   (cfg_dur),
    .cfg_ready (cfg_ready),
    .trig      (trig),
    .dur       (dur),
    .load      (load),
    .deb_level (deb_level),
    .miss_cnt  (miss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and reconcile trig with the scoreboard.
  task automatic tick();
    trig_exp_t e;
    @(negedge clk);
    cyc++;
    if (sb.size() > 0 && cyc >= sb[0].cyc) begin
      e = sb.pop_front();
      chk("trig_expected", 32'(trig), 32'd1);
      if (trig === 1'b1) chk("trig_dur", 32'(dur), 32'(e.dur));
    end else if (trig !== 1'b0) begin
      chk("trig_unexpected", 32'(trig), 32'd0);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_trig"}, 32'(trig), 32'd0);
    chk({tag, "_load"}, 32'(load), 32'd0);
    chk({tag, "_dur"}, 32'(dur), 32'd2);
    chk({tag, "_deb"}, 32'(deb_level), 32'd0);
    chk({tag, "_miss"}, 32'(miss_cnt), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    raw_in    = 1'b0;
    busy      = 1'b0;
    cfg_valid = 1'b0;
    cfg_dur   = 8'd0;

    // Reset and release
    ticks(2);
    chk_reset_vals("in_reset");
    reset = 1'b1;
    tick();
    chk_reset_vals("post_reset");
    chk("post_reset_cfg_ready", 32'(cfg_ready), 32'd1);
    ticks(3);

    // Config then a clean qualified rise
    cfg_valid = 1'b1;
    cfg_dur   = 8'd5;
    tick();
    cfg_valid = 1'b0;
    chk("cfg5_dur", 32'(dur), 32'd5);
    chk("cfg5_load", 32'(load), 32'd1);
    raw_in = 1'b1;
    sb.push_back('{cyc + 7, 8'd5});
    ticks(5);
    chk("deb_before_rise", 32'(deb_level), 32'd0);
    tick();
    chk("deb_rise_at_6", 32'(deb_level), 32'd1);
    ticks(4);
    raw_in = 1'b0;
    ticks(8);
    chk("deb_fall", 32'(deb_level), 32'd0);

    // Glitches shorter than the debounce window
    for (int p = 1; p <= 3; p++) begin
      raw_in = 1'b1;
      ticks(p);
      raw_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (deb_level !== 1'b0) chk("glitch_deb", 32'(deb_level), 32'd0);
      end
      chk("glitch_deb_end", 32'(deb_level), 32'd0);
      chk("glitch_miss", 32'(miss_cnt), 32'd0);
    end

    // Rise while busy is dropped and counted; config stalls while busy
    busy   = 1'b1;
    raw_in = 1'b1;
    ticks(6);
    chk("busy_miss_before", 32'(miss_cnt), 32'd0);
    tick();
    chk("busy_miss_after", 32'(miss_cnt), 32'd1);
    m_exp  = 1;
    raw_in = 1'b0;
    ticks(8);
    cfg_valid = 1'b1;
    cfg_dur   = 8'd9;
    #1;
    chk("stall_cfg_ready", 32'(cfg_ready), 32'd0);
    tick();
    chk("stall_dur_held", 32'(dur), 32'd5);
    busy = 1'b0;
    #1;
    chk("unstall_cfg_ready", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    chk("cfg9_dur", 32'(dur), 32'd9);
    raw_in = 1'b1;
    sb.push_back('{cyc + 7, 8'd9});
    ticks(8);
    raw_in = 1'b0;
    ticks(8);
    chk("miss_still_1", 32'(miss_cnt), 32'd1);

    // Saturation of the miss counter
    busy = 1'b1;
    for (int k = 0; k < 260; k++) begin
      raw_in = 1'b1;
      ticks(7);
      m_exp = (m_exp == 255) ? 255 : m_exp + 1;
      chk("miss_sat", 32'(miss_cnt), 32'(m_exp));
      raw_in = 1'b0;
      ticks(7);
    end
    chk("miss_final_255", 32'(miss_cnt), 32'd255);
    busy = 1'b0;
    ticks(2);

    // Reset in the middle of RISE_CHK
    raw_in = 1'b1;
    ticks(4);
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_rise_chk");
    ticks(2);
    raw_in = 1'b0;
    reset  = 1'b1;
    ticks(8);

    // Reset one clock before trig, then release with raw_in high
    cfg_valid = 1'b1;
    cfg_dur   = 8'd7;
    tick();
    cfg_valid = 1'b0;
    chk("cfg7_load", 32'(load), 32'd1);
    raw_in = 1'b1;
    ticks(6);
    chk("pre_trig_deb", 32'(deb_level), 32'd1);
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_pre_trig");
    ticks(2);
    reset = 1'b1;
    ticks(12);
    chk("held_high_deb", 32'(deb_level), 32'd0);
    chk("held_high_miss", 32'(miss_cnt), 32'd0);

    // First-ever config on the same cycle the rise is evaluated
    raw_in = 1'b0;
    ticks(8);
    raw_in = 1'b1;
    ticks(6);
    chk("first_cfg_deb", 32'(deb_level), 32'd1);
    cfg_valid = 1'b1;
    cfg_dur   = 8'd3;
    tick();
    cfg_valid = 1'b0;
    chk("first_cfg_miss", 32'(miss_cnt), 32'd1);
    chk("first_cfg_load", 32'(load), 32'd1);
    chk("first_cfg_dur", 32'(dur), 32'd3);

    // Config accepted on the same edge as trig
    raw_in = 1'b0;
    ticks(8);
    raw_in = 1'b1;
    sb.push_back('{cyc + 7, 8'd11});
    ticks(6);
    cfg_valid = 1'b1;
    cfg_dur   = 8'd11;
    tick();
    cfg_valid = 1'b0;
    ticks(3);
    raw_in = 1'b0;
    ticks(8);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
